// File: rtl/instr_mem_if.sv
// instr_mem_if: fetch, program-load and status signals of the instruction memory.
//
// Signals
//   fetch_req, fetch_addr, stall      : fetch side, driven by the master
//   inst_valid, inst_dout, inst_fault : fetch result, driven by the memory
//   prog_we, prog_addr, prog_data     : program-load port, driven by the master
//   fetch_cnt                         : saturating count of accepted fetches
//   parity_err                        : parity mismatch on the last fetch
//   force_par_flip                    : test input, present only with IMEM_PARITY_EN
//
// Modports
//   master : fetch stage / loader side
//   slave  : the instruction memory
//
// Build option: IMEM_PARITY_EN adds force_par_flip.
interface instr_mem_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
);
    logic                  fetch_req;
    logic [PC_WIDTH-1:0]   fetch_addr;
    logic                  stall;
    logic                  inst_valid;
    logic [DATA_WIDTH-1:0] inst_dout;
    logic                  inst_fault;
    logic                  prog_we;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DATA_WIDTH-1:0] prog_data;
    logic [31:0]           fetch_cnt;
    logic                  parity_err;
`ifdef IMEM_PARITY_EN
    logic                  force_par_flip;
`endif

    modport master (
        output fetch_req, fetch_addr, stall, prog_we, prog_addr, prog_data,
`ifdef IMEM_PARITY_EN
        output force_par_flip,
`endif
        input  inst_valid, inst_dout, inst_fault, fetch_cnt, parity_err
    );

    modport slave (
        input  fetch_req, fetch_addr, stall, prog_we, prog_addr, prog_data,
`ifdef IMEM_PARITY_EN
        input  force_par_flip,
`endif
        output inst_valid, inst_dout, inst_fault, fetch_cnt, parity_err
    );
endinterface

// File: rtl/instr_mem.sv
// instr_mem: writable instruction memory with a one-cycle registered read,
// valid/stall handshake, alignment/range fault flag, runtime program-load
// port and a saturating fetch counter.
//
// Ports
//   clk : system clock, all logic on the rising edge
//   rst : synchronous active-high reset
//   bus : instr_mem_if.slave (fetch request/response, program load, status)
//
// Build option: IMEM_PARITY_EN stores an even-parity bit per word and
// reports mismatches on parity_err; without it parity_err is tied 0.
module instr_mem #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    PC_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic        clk,
    input  logic        rst,
    instr_mem_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef IMEM_PARITY_EN
    localparam int                 MEM_W      = DATA_WIDTH + 1;
    // Fill words carry correct parity so an unwritten word never flags.
    localparam logic [MEM_W-1:0]   FILL_ENTRY = {^FILL_WORD, FILL_WORD};
`else
    localparam int                 MEM_W      = DATA_WIDTH;
    localparam logic [MEM_W-1:0]   FILL_ENTRY = FILL_WORD;
`endif

    // Power-up contents; reset deliberately does not touch the array.
    logic [MEM_W-1:0] mem [DEPTH] = '{default: FILL_ENTRY};

    logic [ADDR_WIDTH-1:0] index;
    logic                  bad_addr;
    logic                  accept;
    logic                  wr_en;
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      rd_word;
    logic                  par_mismatch;

    logic                  inst_valid_reg;
    logic [DATA_WIDTH-1:0] inst_dout_reg;
    logic                  inst_fault_reg;
    logic [31:0]           fetch_cnt_reg;
    logic                  parity_err_reg;

    assign index    = bus.fetch_addr[ADDR_WIDTH+1:2];
    assign bad_addr = (bus.fetch_addr[1:0] != 2'b00) ||
                      (bus.fetch_addr[PC_WIDTH-1:ADDR_WIDTH+2] != '0);
    assign accept   = bus.fetch_req && !bus.stall;
    assign wr_en    = bus.prog_we && !rst;

`ifdef IMEM_PARITY_EN
    assign wr_word      = {(^bus.prog_data) ^ bus.force_par_flip, bus.prog_data};
    assign par_mismatch = rd_word[MEM_W-1] != (^rd_word[DATA_WIDTH-1:0]);
`else
    assign wr_word      = bus.prog_data;
    assign par_mismatch = 1'b0;
`endif

    // Write-first: a load to the word being fetched this cycle is forwarded.
    assign rd_word = (wr_en && bus.prog_addr == index) ? wr_word : mem[index];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.prog_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid_reg <= 1'b0;
            inst_dout_reg  <= FILL_WORD;
            inst_fault_reg <= 1'b0;
            fetch_cnt_reg  <= '0;
            parity_err_reg <= 1'b0;
        end else if (!bus.stall) begin
            if (accept) begin
                inst_valid_reg <= 1'b1;
                if (fetch_cnt_reg != 32'hFFFF_FFFF) begin
                    fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
                end
                if (bad_addr) begin
                    inst_dout_reg  <= FILL_WORD;
                    inst_fault_reg <= 1'b1;
                    parity_err_reg <= 1'b0;
                end else begin
                    inst_dout_reg  <= rd_word[DATA_WIDTH-1:0];
                    inst_fault_reg <= 1'b0;
                    parity_err_reg <= par_mismatch;
                end
            end else begin
                // Idle cycle: only valid drops; data and flags keep the last fetch.
                inst_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.inst_valid = inst_valid_reg;
    assign bus.inst_dout  = inst_dout_reg;
    assign bus.inst_fault = inst_fault_reg;
    assign bus.fetch_cnt  = fetch_cnt_reg;
`ifdef IMEM_PARITY_EN
    assign bus.parity_err = parity_err_reg;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: doc/instr_mem.md
Name: instr_mem

Overview:
Parametrised, synchronous, writable instruction memory. Successor to the fixed 64-word combinational instruction ROM. Sits between the PC/fetch stage and decode:
- registered read with valid/stall handshake
- alignment and range fault flag
- runtime program-load port
- fetch counter

Parameters:
ADDR_WIDTH, 6, word-address width; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, instruction word width
PC_WIDTH, 32, width of byte-addressed fetch address
FILL_WORD, 32'h0000_0000, nop word; initial contents and fault substitute

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
fetch_req  input  1  fetch request this cycle
fetch_addr  input  PC_WIDTH  byte address of the instruction
stall  input  1  downstream not ready; hold output
inst_valid  output  1  inst_dout/inst_fault hold a completed fetch
inst_dout  output  DATA_WIDTH  fetched instruction (registered)
inst_fault  output  1  last fetch was misaligned or out of range
prog_we  input  1  program-load write enable
prog_addr  input  ADDR_WIDTH  word address for program load
prog_data  input  DATA_WIDTH  word to write
fetch_cnt  output  32  count of accepted fetches, saturating
parity_err  output  1  only with IMEM_PARITY_EN; otherwise tied 0

Behaviour:
- Reset (rst=1 at clock edge):
  - inst_valid=0, inst_dout=FILL_WORD, inst_fault=0, fetch_cnt=0, parity_err=0.
  - Memory array is not cleared; at time zero it is initialised to FILL_WORD.
- Accept rule: a fetch is accepted when fetch_req=1, stall=0 and rst=0.
- Fetch latency: one cycle. A fetch accepted at edge N gives inst_valid=1 and data after edge N (one-cycle registered read).
- No request: when stall=0 and fetch_req=0, inst_valid goes to 0 at the next edge. inst_dout holds its last value.
- Stall: when stall=1, inst_valid, inst_dout, inst_fault and fetch_cnt all hold. fetch_req is ignored, not queued.
- Word index = fetch_addr[ADDR_WIDTH+1:2].
- Misaligned fetch (fetch_addr[1:0] != 0): inst_dout=FILL_WORD, inst_fault=1, inst_valid=1.
- Out-of-range fetch (fetch_addr[PC_WIDTH-1:ADDR_WIDTH+2] != 0): same response as misaligned.
- Good fetch: inst_dout = mem[index], inst_fault=0.
- Program load:
  - prog_we=1 writes prog_data to mem[prog_addr] at the edge, independent of stall.
  - Writes are ignored while rst=1.
- Same-cycle write and fetch to the same word: write-first. The fetch returns prog_data.
- fetch_cnt increments by 1 per accepted fetch, faults included, and saturates at 32'hFFFF_FFFF.
- Reset mid-operation: an in-flight fetch is discarded. inst_valid=0 after the reset edge and no stale data is flagged valid.

Optional Feature:
Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed from prog_data on write. Initial fill words carry correct parity.
  - On a good fetch, parity is recomputed. parity_err is registered alongside inst_dout: 1 on mismatch, 0 otherwise.
  - Faulted fetches set parity_err=0. parity_err holds under stall.
  - A test-only input is added: force_par_flip (1 bit). When high during a write, the stored parity bit is inverted.
- Not defined: no parity storage, parity_err is tied 0, and force_par_flip does not exist.

Test Plan:
1. Reset, then fetch_req=1, addr=0x0 with no prior writes -> after one edge: inst_valid=1, inst_dout=FILL_WORD, inst_fault=0, fetch_cnt=1.
2. Load: prog_we with prog_addr=1, data=32'h0200_0fE7; then fetch 0x4 -> inst_dout=32'h0200_0fE7, inst_fault=0. Back-to-back fetches 0x0, 0x4 give data on consecutive cycles.
3. Fetch 0x6 (misaligned) and 0x100 (out of range for ADDR_WIDTH=6) -> each gives inst_valid=1, inst_fault=1, inst_dout=FILL_WORD. fetch_cnt counts both.
4. Fetch 0x8, then raise stall for 3 cycles while fetch_req=1, addr=0xC -> outputs and fetch_cnt frozen. First fetch after stall drops returns word 3.
5. Same-cycle prog_we to addr 2 with data 32'h01c0_2623, plus fetch 0x8 -> inst_dout=32'h01c0_2623. Then assert rst mid-stream -> inst_valid=0 and fetch_cnt=0 next cycle.
6. With IMEM_PARITY_EN: write word 5 with force_par_flip=1, then fetch 0x14 -> parity_err=1. Fetch an unflipped word -> parity_err=0.
